// File: rtl/picobello_mesh_link_slice.sv
// Elastic link slice for one mesh hop: NumCuts 2-entry skid stages on each of the
// req/rsp/wide channels, plus per-channel output flit and backpressure counters.
module picobello_mesh_link_slice #(
    parameter int unsigned NumCuts   = 1,
    parameter int unsigned ReqWidth  = 128,
    parameter int unsigned RspWidth  = 128,
    parameter int unsigned WideWidth = 600,
    parameter int unsigned CntWidth  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [ReqWidth-1:0]  req_data_i,
    output logic                 req_valid_o,
    input  logic                 req_ready_i,
    output logic [ReqWidth-1:0]  req_data_o,

    input  logic                 rsp_valid_i,
    output logic                 rsp_ready_o,
    input  logic [RspWidth-1:0]  rsp_data_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [RspWidth-1:0]  rsp_data_o,

    input  logic                 wide_valid_i,
    output logic                 wide_ready_o,
    input  logic [WideWidth-1:0] wide_data_i,
    output logic                 wide_valid_o,
    input  logic                 wide_ready_i,
    output logic [WideWidth-1:0] wide_data_o,

    input  logic                 cnt_clear_i,
    output logic [CntWidth-1:0]  req_flits_o,
    output logic [CntWidth-1:0]  rsp_flits_o,
    output logic [CntWidth-1:0]  wide_flits_o,
    output logic [CntWidth-1:0]  req_stalls_o,
    output logic [CntWidth-1:0]  rsp_stalls_o,
    output logic [CntWidth-1:0]  wide_stalls_o
);

    for (genvar c = 0; c < 3; c++) begin : g_ch
        localparam int unsigned W = (c == 0) ? ReqWidth : (c == 1) ? RspWidth : WideWidth;

        // Link k feeds stage k; link NumCuts is the channel output.
        logic [NumCuts:0]        link_valid;
        logic [NumCuts:0]        link_ready;
        logic [NumCuts:0][W-1:0] link_data;

        logic                    out_fire;
        logic                    out_stall;
        logic [CntWidth-1:0]     flits_q, flits_d;
        logic [CntWidth-1:0]     stalls_q, stalls_d;

        if (c == 0) begin : g_req
            assign link_valid[0]       = req_valid_i;
            assign link_data[0]        = req_data_i;
            assign req_ready_o         = link_ready[0];
            assign req_valid_o         = link_valid[NumCuts];
            assign req_data_o          = link_data[NumCuts];
            assign link_ready[NumCuts] = req_ready_i;
            assign req_flits_o         = flits_q;
            assign req_stalls_o        = stalls_q;
        end else if (c == 1) begin : g_rsp
            assign link_valid[0]       = rsp_valid_i;
            assign link_data[0]        = rsp_data_i;
            assign rsp_ready_o         = link_ready[0];
            assign rsp_valid_o         = link_valid[NumCuts];
            assign rsp_data_o          = link_data[NumCuts];
            assign link_ready[NumCuts] = rsp_ready_i;
            assign rsp_flits_o         = flits_q;
            assign rsp_stalls_o        = stalls_q;
        end else begin : g_wide
            assign link_valid[0]       = wide_valid_i;
            assign link_data[0]        = wide_data_i;
            assign wide_ready_o        = link_ready[0];
            assign wide_valid_o        = link_valid[NumCuts];
            assign wide_data_o         = link_data[NumCuts];
            assign link_ready[NumCuts] = wide_ready_i;
            assign wide_flits_o        = flits_q;
            assign wide_stalls_o       = stalls_q;
        end

        for (genvar k = 0; k < NumCuts; k++) begin : g_cut
            logic [1:0]   occ_q, occ_d;
            logic [W-1:0] main_q, main_d;
            logic [W-1:0] skid_q, skid_d;
            logic         in_ready;
            logic         out_valid;
            logic         push;
            logic         pop;

            // Both handshake sides decode the occupancy register only; reset masks them.
            assign in_ready  = (occ_q != 2'd2) && !rst_i;
            assign out_valid = (occ_q != 2'd0) && !rst_i;
            assign push      = link_valid[k] && in_ready;
            assign pop       = out_valid && link_ready[k+1];

            always_comb begin
                occ_d  = occ_q;
                main_d = main_q;
                skid_d = skid_q;
                unique case ({push, pop})
                    2'b10: begin
                        if (occ_q == 2'd0) main_d = link_data[k];
                        else               skid_d = link_data[k];
                        occ_d = occ_q + 2'd1;
                    end
                    2'b01: begin
                        main_d = skid_q;
                        occ_d  = occ_q - 2'd1;
                    end
                    2'b11: begin
                        if (occ_q == 2'd1) begin
                            main_d = link_data[k];
                        end else begin
                            main_d = skid_q;
                            skid_d = link_data[k];
                        end
                    end
                    default: ;
                endcase
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    occ_q  <= '0;
                    main_q <= '0;
                    skid_q <= '0;
                end else begin
                    occ_q  <= occ_d;
                    main_q <= main_d;
                    skid_q <= skid_d;
                end
            end

            assign link_ready[k]   = in_ready;
            assign link_valid[k+1] = out_valid;
            assign link_data[k+1]  = main_q;
        end

        assign out_fire  = link_valid[NumCuts] && link_ready[NumCuts];
        assign out_stall = link_valid[NumCuts] && !link_ready[NumCuts];

        // Counters wrap rather than saturate.
        always_comb begin
            flits_d  = flits_q;
            stalls_d = stalls_q;
            if (out_fire)  flits_d  = flits_q + CntWidth'(1);
            if (out_stall) stalls_d = stalls_q + CntWidth'(1);
        end

        // Clear wins over a same-cycle increment.
        always_ff @(posedge clk_i) begin
            if (rst_i || cnt_clear_i) begin
                flits_q  <= '0;
                stalls_q <= '0;
            end else begin
                flits_q  <= flits_d;
                stalls_q <= stalls_d;
            end
        end
    end

endmodule

// File: tb/tb_picobello_mesh_link_slice.sv
// Directed bench for picobello_mesh_link_slice: three instances (0, 1 and 2 cuts) share
// the stimulus; each phase resets them and checks one instance.
module tb_picobello_mesh_link_slice;

    localparam int unsigned W = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         clr;
    logic         v_in [3];
    logic [W-1:0] d_in [3];
    logic         r_in [3];

    // Indexed [instance][channel]; instance index equals its NumCuts.
    logic         vo [3][3];
    logic         ro [3][3];
    logic [W-1:0] dq [3][3];
    logic [7:0]   fl0 [3];
    logic [7:0]   st0 [3];
    logic [3:0]   fl1 [3];
    logic [3:0]   st1 [3];
    logic [7:0]   fl2 [3];
    logic [7:0]   st2 [3];

    int checks = 0;
    int errors = 0;

    picobello_mesh_link_slice #(
        .NumCuts(0), .ReqWidth(W), .RspWidth(W), .WideWidth(W), .CntWidth(8)
    ) u_dut0 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(v_in[0]), .req_ready_o(ro[0][0]), .req_data_i(d_in[0]),
        .req_valid_o(vo[0][0]), .req_ready_i(r_in[0]), .req_data_o(dq[0][0]),
        .rsp_valid_i(v_in[1]), .rsp_ready_o(ro[0][1]), .rsp_data_i(d_in[1]),
        .rsp_valid_o(vo[0][1]), .rsp_ready_i(r_in[1]), .rsp_data_o(dq[0][1]),
        .wide_valid_i(v_in[2]), .wide_ready_o(ro[0][2]), .wide_data_i(d_in[2]),
        .wide_valid_o(vo[0][2]), .wide_ready_i(r_in[2]), .wide_data_o(dq[0][2]),
        .cnt_clear_i(clr),
        .req_flits_o(fl0[0]), .rsp_flits_o(fl0[1]), .wide_flits_o(fl0[2]),
        .req_stalls_o(st0[0]), .rsp_stalls_o(st0[1]), .wide_stalls_o(st0[2])
    );

    picobello_mesh_link_slice #(
        .NumCuts(1), .ReqWidth(W), .RspWidth(W), .WideWidth(W), .CntWidth(4)
    ) u_dut1 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(v_in[0]), .req_ready_o(ro[1][0]), .req_data_i(d_in[0]),
        .req_valid_o(vo[1][0]), .req_ready_i(r_in[0]), .req_data_o(dq[1][0]),
        .rsp_valid_i(v_in[1]), .rsp_ready_o(ro[1][1]), .rsp_data_i(d_in[1]),
        .rsp_valid_o(vo[1][1]), .rsp_ready_i(r_in[1]), .rsp_data_o(dq[1][1]),
        .wide_valid_i(v_in[2]), .wide_ready_o(ro[1][2]), .wide_data_i(d_in[2]),
        .wide_valid_o(vo[1][2]), .wide_ready_i(r_in[2]), .wide_data_o(dq[1][2]),
        .cnt_clear_i(clr),
        .req_flits_o(fl1[0]), .rsp_flits_o(fl1[1]), .wide_flits_o(fl1[2]),
        .req_stalls_o(st1[0]), .rsp_stalls_o(st1[1]), .wide_stalls_o(st1[2])
    );

    picobello_mesh_link_slice #(
        .NumCuts(2), .ReqWidth(W), .RspWidth(W), .WideWidth(W), .CntWidth(8)
    ) u_dut2 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(v_in[0]), .req_ready_o(ro[2][0]), .req_data_i(d_in[0]),
        .req_valid_o(vo[2][0]), .req_ready_i(r_in[0]), .req_data_o(dq[2][0]),
        .rsp_valid_i(v_in[1]), .rsp_ready_o(ro[2][1]), .rsp_data_i(d_in[1]),
        .rsp_valid_o(vo[2][1]), .rsp_ready_i(r_in[1]), .rsp_data_o(dq[2][1]),
        .wide_valid_i(v_in[2]), .wide_ready_o(ro[2][2]), .wide_data_i(d_in[2]),
        .wide_valid_o(vo[2][2]), .wide_ready_i(r_in[2]), .wide_data_o(dq[2][2]),
        .cnt_clear_i(clr),
        .req_flits_o(fl2[0]), .rsp_flits_o(fl2[1]), .wide_flits_o(fl2[2]),
        .req_stalls_o(st2[0]), .rsp_stalls_o(st2[1]), .wide_stalls_o(st2[2])
    );

    logic [W-1:0] sb [3][$];
    int           nf [3];
    int           ns [3];
    logic         acc [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clr = 1'b0;
        for (int c = 0; c < 3; c++) begin
            v_in[c] = 1'b0;
            r_in[c] = 1'b0;
            d_in[c] = '0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Scoreboard pop for instance 1; an unexpected flit is compared against X.
    task automatic deliver(input int c);
        logic [W-1:0] e;
        if (vo[1][c] && r_in[c]) begin
            e = (sb[c].size() != 0) ? sb[c].pop_front() : 'x;
            chk("f_data", dq[1][c], e);
            nf[c]++;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int nexp;
        int sent;
        int got;
        rst = 1'b1;
        clr = 1'b0;

        // Reset state and 100-flit stream through two cuts.
        do_reset();
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("a_rst_ready", ro[2][c], 1);
            chk("a_rst_valid", vo[2][c], 0);
            chk("a_rst_data", dq[2][c], 0);
            chk("a_rst_flits", fl2[c], 0);
            chk("a_rst_stalls", st2[c], 0);
        end
        nexp = 0;
        for (int t = 0; t < 105; t++) begin
            @(negedge clk);
            v_in[0] = (t < 100);
            d_in[0] = W'(t);
            r_in[0] = 1'b1;
            #1;
            chk("a_ready", ro[2][0], 1);
            chk("a_valid", vo[2][0], (t >= 2 && t < 102));
            if (vo[2][0]) begin
                chk("a_data", dq[2][0], nexp);
                nexp++;
            end
        end
        @(negedge clk);
        #1;
        chk("a_count", nexp, 100);
        chk("a_flits", fl2[0], 100);
        chk("a_stalls", st2[0], 0);

        // Backpressure on wide, one cut.
        do_reset();
        sent = 0;
        got  = 0;
        for (int k = 0; k < 40 && got < 5; k++) begin
            @(negedge clk);
            v_in[2] = (sent < 5);
            d_in[2] = W'(24'hA0 + sent);
            r_in[2] = (k >= 11);
            #1;
            if (k == 1)  chk("b_ready_open", ro[1][2], 1);
            if (k == 2)  chk("b_ready_full", ro[1][2], 0);
            if (k == 10) chk("b_ready_held", ro[1][2], 0);
            if (vo[1][2] && r_in[2]) begin
                chk("b_data", dq[1][2], 32'hA0 + got);
                got++;
            end
            if (v_in[2] && ro[1][2]) sent++;
        end
        v_in[2] = 1'b0;
        @(negedge clk);
        #1;
        chk("b_got", got, 5);
        chk("b_flits", fl1[2], 5);
        chk("b_stalls", st1[2], 10);

        // 4-bit counter wrap and clear priority on req.
        do_reset();
        r_in[0] = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            v_in[0] = 1'b1;
            d_in[0] = W'(k);
        end
        @(negedge clk);
        v_in[0] = 1'b0;
        @(negedge clk);
        #1;
        chk("c_flits_15", fl1[0], 15);
        v_in[0] = 1'b1;
        @(negedge clk);
        v_in[0] = 1'b0;
        @(negedge clk);
        #1;
        chk("c_wrap", fl1[0], 0);
        chk("c_stalls", st1[0], 0);
        v_in[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        v_in[0] = 1'b0;
        clr     = 1'b1;
        #1;
        chk("c_pre_clear", fl1[0], 1);
        chk("c_clr_fire", vo[1][0], 1);
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("c_clear_prio", fl1[0], 0);
        @(negedge clk);
        #1;
        chk("c_clear_hold", fl1[0], 0);

        // Reset while every channel holds two flits.
        do_reset();
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            v_in[c] = 1'b1;
            d_in[c] = W'(24'h5500 + c);
        end
        @(negedge clk);
        for (int c = 0; c < 3; c++) d_in[c] = W'(24'h6600 + c);
        @(negedge clk);
        for (int c = 0; c < 3; c++) v_in[c] = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("d_full_ready", ro[1][c], 0);
            chk("d_full_valid", vo[1][c], 1);
            chk("d_full_data", dq[1][c], 32'h5500 + c);
            chk("d_full_stalls", st1[c], 1);
        end
        rst = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("d_inrst_ready", ro[1][c], 0);
            chk("d_inrst_valid", vo[1][c], 0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("d_post_valid", vo[1][c], 0);
            chk("d_post_ready", ro[1][c], 1);
            chk("d_post_flits", fl1[c], 0);
            chk("d_post_stalls", st1[c], 0);
            r_in[c] = 1'b1;
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            for (int c = 0; c < 3; c++) chk("d_no_ghost", vo[1][c], 0);
        end

        // Zero cuts: outputs follow inputs within the cycle.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            nf[c] = 0;
            ns[c] = 0;
        end
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            for (int c = 0; c < 3; c++) begin
                v_in[c] = 1'($urandom_range(0, 1));
                r_in[c] = 1'($urandom_range(0, 1));
                d_in[c] = W'($urandom);
            end
            #1;
            for (int c = 0; c < 3; c++) begin
                chk("e_valid", vo[0][c], v_in[c]);
                chk("e_data", dq[0][c], d_in[c]);
                chk("e_ready", ro[0][c], r_in[c]);
                if (v_in[c] && r_in[c])  nf[c]++;
                if (v_in[c] && !r_in[c]) ns[c]++;
            end
        end
        @(negedge clk);
        for (int c = 0; c < 3; c++) v_in[c] = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("e_flits", fl0[c], nf[c]);
            chk("e_stalls", st0[c], ns[c]);
        end

        // Concurrent random traffic on one cut against per-channel scoreboards.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            nf[c]  = 0;
            ns[c]  = 0;
            acc[c] = 1'b0;
        end
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            for (int c = 0; c < 3; c++) begin
                if (!v_in[c] || acc[c]) begin
                    v_in[c] = ($urandom_range(0, 3) <= c);
                    d_in[c] = W'((c << 16) + ns[c]);
                end
                r_in[c] = ($urandom_range(0, 9) < 3 + 3 * c);
            end
            #1;
            for (int c = 0; c < 3; c++) deliver(c);
            for (int c = 0; c < 3; c++) begin
                acc[c] = v_in[c] && ro[1][c];
                if (acc[c]) begin
                    sb[c].push_back(d_in[c]);
                    ns[c]++;
                end
            end
        end
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            v_in[c] = 1'b0;
            r_in[c] = 1'b1;
        end
        for (int k = 0; k < 4; k++) begin
            #1;
            for (int c = 0; c < 3; c++) deliver(c);
            @(negedge clk);
        end
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("f_drained", sb[c].size(), 0);
            chk("f_all_out", nf[c], ns[c]);
            chk("f_flits", fl1[c], nf[c] % 16);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
